// File: rtl/data_memory_ls.sv
// Byte-addressable data memory for the MEM stage: RISC-V B/H/W loads and stores,
// fault reporting, valid/ready request port with a registered one-cycle response.
module data_memory_ls #(
  parameter int DEPTH          = 256,
  parameter int ADDR_WIDTH     = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  we,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rdata,
  output logic                  fault,
  output logic                  busy,
  output logic                  state_dbg
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic [31:0]      mem_q [DEPTH];

  logic             rsp_valid_q;
  logic [31:0]      rdata_q;
  logic             fault_q;

  // Handshake: a request transfers on a rising edge where req_valid and req_ready
  // are both high and reset is low; the requester holds it stable until then.
  // rsp_valid pulses for exactly one cycle after each transfer.
  logic             accept;
  logic [IDX_W-1:0] idx;
  logic [1:0]       off;
  logic             illegal_f3, out_of_range, misaligned, req_fault;
  logic [3:0]       lane_en;
  logic [31:0]      lane_data;
  logic [31:0]      rd_word;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [31:0]      load_res;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RST_STATE;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == ST_CLEAR) begin
      clr_idx_d = clr_idx_q + 1'b1;
      if (clr_idx_q == IDX_W'(DEPTH - 1)) state_d = ST_IDLE;
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    busy      = (state_q == ST_CLEAR);
    state_dbg = state_q;
  end

  assign accept = req_valid & req_ready & ~reset;
  assign idx    = addr[IDX_W+1:2];
  assign off    = addr[1:0];

  // Fault decode; any one of these suppresses the array write and the load data.
  always_comb begin
    illegal_f3   = funct3 inside {3'b011, 3'b110, 3'b111};
    out_of_range = |addr[ADDR_WIDTH-1:IDX_W+2];
    misaligned   = ((funct3[1:0] == 2'b01) && off[0]) ||
                   ((funct3[1:0] == 2'b10) && (off != 2'b00));
    req_fault    = illegal_f3 | out_of_range | misaligned;
  end

  // Store data is replicated across lanes so each enabled lane picks its own slice.
  always_comb begin
    lane_en   = 4'b0000;
    lane_data = wdata;
    case (funct3[1:0])
      2'b00: begin
        lane_en   = 4'b0001 << off;
        lane_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        lane_en   = off[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata[15:0]}};
      end
      default: begin
        lane_en   = 4'b1111;
        lane_data = wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        mem_q[clr_idx_q] <= '0;
      end else if (accept && we && !req_fault) begin
        for (int l = 0; l < 4; l++) begin
          if (lane_en[l]) mem_q[idx][8*l +: 8] <= lane_data[8*l +: 8];
        end
      end
    end
  end

  // Load extraction reads the array before this edge's write, so a store accepted
  // on the previous edge is already visible.
  always_comb begin
    rd_word  = mem_q[idx];
    rd_byte  = rd_word[{off, 3'b000} +: 8];
    rd_half  = off[1] ? rd_word[31:16] : rd_word[15:0];
    load_res = '0;
    case (funct3)
      3'b000:  load_res = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_res = {{16{rd_half[15]}}, rd_half};
      3'b010:  load_res = rd_word;
      3'b100:  load_res = {24'h0, rd_byte};
      3'b101:  load_res = {16'h0, rd_half};
      default: load_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      fault_q     <= 1'b0;
    end else begin
      rsp_valid_q <= accept;
      if (accept) begin
        fault_q <= req_fault;
        rdata_q <= (we || req_fault) ? 32'h0 : load_res;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rdata     = rdata_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_data_memory_ls.sv
// Directed bench for data_memory_ls: clear sequencer, lane merging, extension,
// faults, reset behaviour, and the no-clear configuration.
module tb_data_memory_ls;

  logic clk;

  // Instance A: clears on reset
  logic        a_reset, a_req_valid, a_req_ready, a_we;
  logic [2:0]  a_funct3;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        a_rsp_valid, a_fault, a_busy, a_state;

  // Instance B: contents survive reset
  logic        b_reset, b_req_valid, b_req_ready, b_we;
  logic [2:0]  b_funct3;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic        b_rsp_valid, b_fault, b_busy, b_state;

  logic [32:0] exp_q[$];
  logic [31:0] last_rd;
  int          n_checks;
  int          n_fail;
  logic [7:0]  model_b [16];

  data_memory_ls #(.DEPTH(256), .ADDR_WIDTH(32), .CLEAR_ON_RESET(1)) u_dut_a (
    .clk(clk), .reset(a_reset), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .we(a_we), .funct3(a_funct3), .addr(a_addr), .wdata(a_wdata),
    .rsp_valid(a_rsp_valid), .rdata(a_rdata), .fault(a_fault), .busy(a_busy),
    .state_dbg(a_state)
  );

  data_memory_ls #(.DEPTH(256), .ADDR_WIDTH(32), .CLEAR_ON_RESET(0)) u_dut_b (
    .clk(clk), .reset(b_reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .we(b_we), .funct3(b_funct3), .addr(b_addr), .wdata(b_wdata),
    .rsp_valid(b_rsp_valid), .rdata(b_rdata), .fault(b_fault), .busy(b_busy),
    .state_dbg(b_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [32:0] e;
    if (a_rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", {a_fault, a_rdata}, 33'h0_dead_dead);
      end else begin
        e = exp_q.pop_front();
        chk("rsp", {a_fault, a_rdata}, e);
        last_rd = e[31:0];
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send(input logic w, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] d, input logic exp_f, input logic [31:0] exp_d);
    int n = 0;
    a_req_valid = 1'b1;
    a_we        = w;
    a_funct3    = f3;
    a_addr      = a;
    a_wdata     = d;
    while (a_req_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready_timeout", 33'(n >= 1000), 33'h0);
    exp_q.push_back({exp_f, exp_d});
    @(negedge clk);
  endtask

  task automatic idle_a();
    a_req_valid = 1'b0;
    @(negedge clk);
    chk("idle_no_rsp", 33'(a_rsp_valid), 33'h0);
    chk("rdata_hold", {1'b0, a_rdata}, {1'b0, last_rd});
  endtask

  task automatic measure_clear(input string tag);
    int cnt = 0;
    int bad = 0;
    while (a_busy === 1'b1 && cnt < 1000) begin
      if (a_req_ready !== 1'b0) bad++;
      cnt++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 33'(cnt), 33'd256);
    chk({tag, "_ready_low"}, 33'(bad), 33'd0);
    chk({tag, "_ready_after"}, {a_busy, 31'h0, a_req_ready}, 33'h1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] rnd;
    int          o;
    n_checks = 0;
    n_fail   = 0;
    last_rd  = '0;
    a_reset = 1'b1; a_req_valid = 1'b0; a_we = 1'b0; a_funct3 = 3'b010; a_addr = '0; a_wdata = '0;
    b_reset = 1'b1; b_req_valid = 1'b0; b_we = 1'b0; b_funct3 = 3'b010; b_addr = '0; b_wdata = '0;
    for (int i = 0; i < 16; i++) model_b[i] = 8'h00;

    @(negedge clk);
    chk("reset_rsp_valid", 33'(a_rsp_valid), 33'h0);
    chk("reset_rdata_fault", {a_fault, a_rdata}, 33'h0);
    chk("reset_busy_ready", {31'h0, a_busy, a_req_ready}, 33'h2);
    @(negedge clk);
    a_reset = 1'b0;
    b_reset = 1'b0;
    measure_clear("clear1");

    send(1'b0, 3'b010, 32'h3FC, 32'h0, 1'b0, 32'h0000_0000);

    // lane merge, store-then-load back to back
    send(1'b1, 3'b010, 32'h10, 32'h1122_3344, 1'b0, 32'h0);
    send(1'b1, 3'b000, 32'h11, 32'hFFFF_FFAA, 1'b0, 32'h0);
    send(1'b1, 3'b001, 32'h12, 32'h1234_BEEF, 1'b0, 32'h0);
    send(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hBEEF_AA44);
    idle_a();

    send(1'b0, 3'b000, 32'h11, 32'h0, 1'b0, 32'hFFFF_FFAA);
    send(1'b0, 3'b100, 32'h11, 32'h0, 1'b0, 32'h0000_00AA);
    send(1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 32'hFFFF_BEEF);
    send(1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 32'h0000_BEEF);
    send(1'b0, 3'b000, 32'h10, 32'h0, 1'b0, 32'h0000_0044);
    send(1'b0, 3'b001, 32'h10, 32'h0, 1'b0, 32'hFFFF_AA44);
    idle_a();
    idle_a();

    // faults must not write
    send(1'b1, 3'b010, 32'h20, 32'h5566_7788, 1'b0, 32'h0);
    send(1'b1, 3'b010, 32'h21, 32'hDEAD_BEEF, 1'b1, 32'h0);
    send(1'b0, 3'b001, 32'h13, 32'h0, 1'b1, 32'h0);
    send(1'b1, 3'b011, 32'h20, 32'hFFFF_FFFF, 1'b1, 32'h0);
    send(1'b1, 3'b000, 32'h420, 32'h0000_0011, 1'b1, 32'h0);
    send(1'b0, 3'b010, 32'h400, 32'h0, 1'b1, 32'h0);
    send(1'b0, 3'b010, 32'h12, 32'h0, 1'b1, 32'h0);
    send(1'b0, 3'b101, 32'h21, 32'h0, 1'b1, 32'h0);
    send(1'b1, 3'b111, 32'h20, 32'h0, 1'b1, 32'h0);
    send(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'h5566_7788);
    idle_a();

    // random byte stores against a byte model
    for (int i = 0; i < 10; i++) begin
      o   = $urandom_range(0, 15);
      rnd = $urandom;
      send(1'b1, 3'b000, 32'h80 + 32'(o), rnd, 1'b0, 32'h0);
      model_b[o] = rnd[7:0];
    end
    for (int i = 0; i < 16; i++) begin
      send(1'b0, 3'b100, 32'h80 + 32'(i), 32'h0, 1'b0, {24'h0, model_b[i]});
      send(1'b0, 3'b000, 32'h80 + 32'(i), 32'h0, 1'b0, {{24{model_b[i][7]}}, model_b[i]});
    end
    idle_a();

    // reset right after a load accept, with a request still presented
    send(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hBEEF_AA44);
    a_reset = 1'b1;
    @(negedge clk);
    last_rd = '0;
    chk("reset_drops_rsp", {a_rsp_valid, a_rdata}, 33'h0);
    chk("reset_mid_traffic_busy", 33'(a_busy), 33'h1);
    a_req_valid = 1'b0;
    a_reset = 1'b0;
    for (int i = 0; i < 100; i++) @(negedge clk);
    a_reset = 1'b1;
    @(negedge clk);
    a_reset = 1'b0;
    measure_clear("clear_restart");
    send(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h0000_0000);
    idle_a();
    chk("scoreboard_drained", 33'(exp_q.size()), 33'h0);

    // instance without clear-on-reset
    chk("b_ready_idle", 33'(b_req_ready), 33'h1);
    b_req_valid = 1'b1; b_we = 1'b1; b_funct3 = 3'b010; b_addr = 32'h40; b_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    b_req_valid = 1'b0;
    chk("b_store_rsp", {b_rsp_valid, b_fault}, 33'h2);
    b_reset = 1'b1;
    @(negedge clk);
    b_reset = 1'b0;
    chk("b_ready_after_reset", {31'h0, b_busy, b_req_ready}, 33'h1);
    chk("b_rsp_after_reset", 33'(b_rsp_valid), 33'h0);
    b_req_valid = 1'b1; b_we = 1'b0; b_funct3 = 3'b010; b_addr = 32'h40;
    @(negedge clk);
    b_req_valid = 1'b0;
    chk("b_load_valid", {b_rsp_valid, b_fault}, 33'h2);
    chk("b_load_data", {1'b0, b_rdata}, {1'b0, 32'hCAFE_F00D});
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
